// File: rtl/rx_8b10b_pkg.sv
// ============================================================================
// Module  : rx_8b10b_pkg
// Brief   : Shared constants, state encoding and helpers for the receive-side
//           8b10b symbol-lock path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_8b10b_pkg;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    function automatic logic [3:0] ones10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic is_k28_5(input logic [9:0] v);
        return (v == K28_5_RDN) || (v == K28_5_RDP);
    endfunction

    // Offset k selects window bits [19-k : 10-k]; bit 19 is the oldest received bit.
    function automatic logic [9:0] cand_at(input logic [19:0] w, input logic [3:0] k);
        logic [19:0] s;
        s = w >> (4'd10 - k);
        return s[9:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_comma_search.sv
// ============================================================================
// Module  : rx_comma_search
// Brief   : Checks all 10 bit offsets of a 20-bit window for K28.5 and reports
//           the lowest matching offset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_comma_search
    import rx_8b10b_pkg::*;
(
    input  logic [19:0] window,
    output logic        hit,
    output logic [3:0]  hit_offset,
    output logic [9:0]  hit_at
);

    generate
        for (genvar k = 0; k < 10; k++) begin : g_offset
            assign hit_at[k] = is_k28_5(window[19-k -: 10]);
        end
    endgenerate

    // Scan downward so the lowest matching offset is the last one written.
    always_comb begin
        hit_offset = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (hit_at[k]) begin
                hit_offset = 4'(k);
            end
        end
    end

    assign hit = |hit_at;

endmodule

`default_nettype wire

// File: rtl/rx_symbol_lock_ctrl.sv
// ============================================================================
// Module  : rx_symbol_lock_ctrl
// Brief   : Comma hunt/verify/lock controller aligning deserialized words for
//           the 10b8b decoder. Define RX_DISP_CHECK_EN to add running-disparity
//           checking while locked.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_symbol_lock_ctrl
    import rx_8b10b_pkg::*;
#(
    parameter int COMMA_LOCK_CNT   = 3,
    parameter int ERR_LOSS_CNT     = 4,
    parameter int GOOD_RECOVER_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_valid,
    input  logic [9:0] raw_in,
    output logic [9:0] sym_out,
    output logic       sym_valid,
    output logic       sym_is_comma,
    output logic       sym_err,
    output logic       locked,
    output logic [3:0] align_offset
);

    localparam logic [3:0] c_lock_cnt = 4'(COMMA_LOCK_CNT);
    localparam logic [3:0] c_loss_cnt = 4'(ERR_LOSS_CNT);
    localparam logic [7:0] c_good_cnt = 8'(GOOD_RECOVER_CNT);

    lock_state_t r_state, w_state_nxt;
    logic [9:0]  r_prev, w_prev_nxt;
    logic [3:0]  r_offset, w_offset_nxt;
    logic [3:0]  r_comma_cnt, w_comma_cnt_nxt;
    logic [3:0]  r_err_cnt, w_err_cnt_nxt;
    logic [7:0]  r_good_cnt, w_good_cnt_nxt;
    logic [9:0]  r_sym, w_sym_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_is_comma, w_is_comma_nxt;
    logic        r_err, w_err_nxt;

    logic [19:0] w_window;
    logic        w_hit;
    logic [3:0]  w_hit_offset;
    logic [9:0]  w_hit_at;
    logic [9:0]  w_cand;
    logic [3:0]  w_ones;
    logic        w_ones_err;
    logic        w_lat_comma;
    logic [3:0]  w_err_inc;
    logic        w_disp_err;

    assign w_window = {r_prev, raw_in};

    rx_comma_search u_search (
        .window     (w_window),
        .hit        (w_hit),
        .hit_offset (w_hit_offset),
        .hit_at     (w_hit_at)
    );

    assign w_cand      = cand_at(w_window, r_offset);
    assign w_ones      = ones10(w_cand);
    assign w_ones_err  = (w_ones < 4'd4) || (w_ones > 4'd6);
    assign w_lat_comma = w_hit_at[r_offset];
    assign w_err_inc   = (r_err_cnt == 4'hF) ? r_err_cnt : r_err_cnt + 4'd1;

`ifdef RX_DISP_CHECK_EN
    logic r_rd, w_rd_nxt;  // 1 = positive running disparity
    assign w_disp_err = ((w_ones == 4'd6) && r_rd) || ((w_ones == 4'd4) && !r_rd);
`else
    assign w_disp_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_offset_nxt    = r_offset;
        w_comma_cnt_nxt = r_comma_cnt;
        w_err_cnt_nxt   = r_err_cnt;
        w_good_cnt_nxt  = r_good_cnt;
        w_sym_nxt       = r_sym;
        w_is_comma_nxt  = r_is_comma;
        w_valid_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
`ifdef RX_DISP_CHECK_EN
        w_rd_nxt        = r_rd;
`endif
        if (raw_valid) begin
            w_prev_nxt     = raw_in;
            w_sym_nxt      = w_cand;
            w_is_comma_nxt = is_k28_5(w_cand);
            case (r_state)
                HUNT: begin
                    if (w_hit) begin
                        w_offset_nxt    = w_hit_offset;
                        w_comma_cnt_nxt = 4'd1;
                        if (c_lock_cnt <= 4'd1) begin
                            w_state_nxt    = LOCKED;
                            w_err_cnt_nxt  = 4'd0;
                            w_good_cnt_nxt = 8'd0;
`ifdef RX_DISP_CHECK_EN
                            w_rd_nxt = (cand_at(w_window, w_hit_offset) == K28_5_RDN);
`endif
                        end else begin
                            w_state_nxt = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (w_lat_comma) begin
                        w_comma_cnt_nxt = (r_comma_cnt == 4'hF) ? r_comma_cnt : r_comma_cnt + 4'd1;
                        if (r_comma_cnt + 4'd1 >= c_lock_cnt) begin
                            w_state_nxt    = LOCKED;
                            w_err_cnt_nxt  = 4'd0;
                            w_good_cnt_nxt = 8'd0;
`ifdef RX_DISP_CHECK_EN
                            w_rd_nxt = (w_cand == K28_5_RDN);
`endif
                        end
                    end else if (w_hit) begin
                        w_offset_nxt    = w_hit_offset;
                        w_comma_cnt_nxt = 4'd1;
                    end else if (w_ones_err) begin
                        w_state_nxt     = HUNT;
                        w_comma_cnt_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    w_valid_nxt = 1'b1;
                    // An error always wins over a pending good-run rollover.
                    if (w_ones_err || w_disp_err) begin
                        w_err_nxt      = 1'b1;
                        w_good_cnt_nxt = 8'd0;
                        w_err_cnt_nxt  = w_err_inc;
                        if (w_err_inc >= c_loss_cnt) begin
                            w_state_nxt     = HUNT;
                            w_comma_cnt_nxt = 4'd0;
                        end
                    end else if (r_good_cnt + 8'd1 >= c_good_cnt) begin
                        w_good_cnt_nxt = 8'd0;
                        if (r_err_cnt != 4'd0) begin
                            w_err_cnt_nxt = r_err_cnt - 4'd1;
                        end
                    end else begin
                        w_good_cnt_nxt = r_good_cnt + 8'd1;
                    end
`ifdef RX_DISP_CHECK_EN
                    if (w_ones == 4'd6) begin
                        w_rd_nxt = 1'b1;
                    end else if (w_ones == 4'd4) begin
                        w_rd_nxt = 1'b0;
                    end
`endif
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_prev      <= 10'd0;
            r_offset    <= 4'd0;
            r_comma_cnt <= 4'd0;
            r_err_cnt   <= 4'd0;
            r_good_cnt  <= 8'd0;
            r_sym       <= 10'd0;
            r_valid     <= 1'b0;
            r_is_comma  <= 1'b0;
            r_err       <= 1'b0;
`ifdef RX_DISP_CHECK_EN
            r_rd        <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_offset    <= w_offset_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_good_cnt  <= w_good_cnt_nxt;
            r_sym       <= w_sym_nxt;
            r_valid     <= w_valid_nxt;
            r_is_comma  <= w_is_comma_nxt;
            r_err       <= w_err_nxt;
`ifdef RX_DISP_CHECK_EN
            r_rd        <= w_rd_nxt;
`endif
        end
    end

    assign sym_out      = r_sym;
    assign sym_valid    = r_valid;
    assign sym_is_comma = r_is_comma;
    assign sym_err      = r_err;
    assign locked       = (r_state == LOCKED);
    assign align_offset = r_offset;

endmodule

`default_nettype wire

// File: tb/tb_rx_symbol_lock_ctrl.sv
// ============================================================================
// Module  : tb_rx_symbol_lock_ctrl
// Brief   : Self-checking bench for rx_symbol_lock_ctrl against a bit-stream
//           reference model. Honours RX_DISP_CHECK_EN like the design.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_symbol_lock_ctrl;

    localparam int COMMA_LOCK_CNT   = 3;
    localparam int ERR_LOSS_CNT     = 4;
    localparam int GOOD_RECOVER_CNT = 16;

    localparam logic [9:0] K_RDN = 10'b0011111010;
    localparam logic [9:0] K_RDP = 10'b1100000101;
    localparam logic [9:0] D21_5 = 10'b1010101010;
    localparam logic [9:0] BAD   = 10'b1111111100;
    localparam logic [9:0] ONES6 = 10'b1110011100;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_valid;
    logic [9:0] raw_in;
    logic [9:0] sym_out;
    logic       sym_valid;
    logic       sym_is_comma;
    logic       sym_err;
    logic       locked;
    logic [3:0] align_offset;

    always #5 clk = ~clk;

    rx_symbol_lock_ctrl #(
        .COMMA_LOCK_CNT   (COMMA_LOCK_CNT),
        .ERR_LOSS_CNT     (ERR_LOSS_CNT),
        .GOOD_RECOVER_CNT (GOOD_RECOVER_CNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_valid    (raw_valid),
        .raw_in       (raw_in),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
        .sym_is_comma (sym_is_comma),
        .sym_err      (sym_err),
        .locked       (locked),
        .align_offset (align_offset)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Serial line: bits in arrival order, cut into raw words 10 at a time.
    bit bitq[$];

    // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
    int         m_mode, m_off, m_ccnt, m_err, m_good;
    bit         m_rd;
    logic [9:0] m_prev;
    bit         e_valid, e_err, e_comma;
    logic [9:0] e_sym;
    logic [17:0] m_exp;

    function automatic logic [17:0] obs_vec();
        return {sym_valid, locked, align_offset,
                sym_valid ? {sym_out, sym_err, sym_is_comma} : 12'd0};
    endfunction

    task automatic reset_model();
        m_mode = 0; m_off = 0; m_ccnt = 0; m_err = 0; m_good = 0;
        m_rd = 1'b0; m_prev = 10'd0;
        e_valid = 1'b0; e_err = 1'b0; e_comma = 1'b0; e_sym = 10'd0;
    endtask

    task automatic model_lock(input logic [9:0] cm);
        m_mode = 2; m_err = 0; m_good = 0;
        m_rd = (cm == K_RDN);
    endtask

    task automatic model_word(input bit v, input logic [9:0] w);
        logic [19:0] win;
        logic [9:0]  c [10];
        int          first, ones;
        bit          bad;
        if (!v) begin
            e_valid = 1'b0;
            e_err   = 1'b0;
            return;
        end
        win   = {m_prev, w};
        first = -1;
        for (int k = 0; k < 10; k++) begin
            c[k] = 10'(win >> (10 - k));
            if (first < 0 && (c[k] == K_RDN || c[k] == K_RDP)) first = k;
        end
        e_sym   = c[m_off];
        ones    = $countones(e_sym);
        bad     = (ones < 4) || (ones > 6);
`ifdef RX_DISP_CHECK_EN
        if (m_mode == 2 && ((ones == 6 && m_rd) || (ones == 4 && !m_rd))) bad = 1'b1;
`endif
        e_valid = (m_mode == 2);
        e_comma = (e_sym == K_RDN) || (e_sym == K_RDP);
        e_err   = e_valid && bad;
        m_prev  = w;
        if (m_mode == 0) begin
            if (first >= 0) begin
                m_off = first; m_ccnt = 1;
                if (m_ccnt >= COMMA_LOCK_CNT) model_lock(c[first]);
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (e_comma) begin
                m_ccnt++;
                if (m_ccnt >= COMMA_LOCK_CNT) model_lock(e_sym);
            end else if (first >= 0) begin
                m_off = first; m_ccnt = 1;
            end else if (bad) begin
                m_mode = 0; m_ccnt = 0;
            end
        end else begin
            if (bad) begin
                m_good = 0;
                if (m_err < 15) m_err++;
                if (m_err >= ERR_LOSS_CNT) begin m_mode = 0; m_ccnt = 0; end
            end else begin
                m_good++;
                if (m_good >= GOOD_RECOVER_CNT) begin
                    m_good = 0;
                    if (m_err > 0) m_err--;
                end
            end
`ifdef RX_DISP_CHECK_EN
            if (ones == 6) m_rd = 1'b1;
            else if (ones == 4) m_rd = 1'b0;
`endif
        end
    endtask

    task automatic step(input bit v, input logic [9:0] w);
        raw_valid = v;
        raw_in    = w;
        model_word(v, w);
        @(posedge clk);
        #1;
        m_exp = {e_valid, (m_mode == 2), 4'(m_off),
                 e_valid ? {e_sym, e_err, e_comma} : 12'd0};
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) bitq.push_back(s[i]);
    endtask

    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) bitq.push_back(i[0] ? 1'b0 : 1'b1);
    endtask

    task automatic push_commas(input int n);
        for (int i = 0; i < n; i++) begin
            push_sym(K_RDN); push_sym(D21_5); push_sym(D21_5);
        end
    endtask

    task automatic pop_word(output logic [9:0] w);
        w = 10'd0;
        for (int i = 0; i < 10; i++) w = {w[8:0], bitq.pop_front()};
    endtask

    task automatic do_reset();
        rst = 1'b1; raw_valid = 1'b0; raw_in = 10'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
        bitq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; raw_valid = 1'b0; raw_in = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (sym_out !== 10'd0) begin n_fail++; $display("FAIL reset_sym_out: got %h want 000", sym_out); end
        n_cmp++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
        n_cmp++; if (sym_is_comma !== 1'b0) begin n_fail++; $display("FAIL reset_sym_is_comma: got %b want 0", sym_is_comma); end
        n_cmp++; if (sym_err !== 1'b0) begin n_fail++; $display("FAIL reset_sym_err: got %b want 0", sym_err); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (align_offset !== 4'd0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", align_offset); end
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 10'($urandom));
            n_cmp++; if (obs_vec() !== 18'd0) begin n_fail++; $display("FAIL idle_outputs: got %h want 0", obs_vec()); end
        end
    endtask

    task automatic test_lock_acquire();
        logic [9:0] w;
        bit pl, rose, saw_data;
        rose = 1'b0; saw_data = 1'b0;
        push_fill(3); push_sym(D21_5);
        push_commas(3);
        push_sym(D21_5); push_sym(D21_5);
        while (bitq.size() >= 10) begin
            pl = locked;
            pop_word(w); step(1'b1, w);
            n_cmp++; if (obs_vec() !== m_exp) begin n_fail++; $display("FAIL acquire_cycle: got %h want %h", obs_vec(), m_exp); end
            if (!pl && locked) begin
                rose = 1'b1;
                n_cmp++; if (sym_out !== K_RDN) begin n_fail++; $display("FAIL acquire_rise_sym: got %h want %h", sym_out, K_RDN); end
            end
            if (rose && sym_valid && sym_out == D21_5) saw_data = 1'b1;
        end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL acquire_locked: got %b want 1", locked); end
        n_cmp++; if (align_offset !== 4'd3) begin n_fail++; $display("FAIL acquire_offset: got %0d want 3", align_offset); end
        n_cmp++; if (saw_data !== 1'b1) begin n_fail++; $display("FAIL acquire_data_valid: got %b want 1", saw_data); end
    endtask

    task automatic test_err_loss();
        logic [9:0] w;
        bit pl;
        int errs;
        errs = 0;
        push_sym(D21_5); push_sym(D21_5);
        for (int i = 0; i < 4; i++) begin
            push_sym(BAD); push_sym(D21_5); push_sym(D21_5);
        end
        while (bitq.size() >= 10) begin
            pl = locked;
            pop_word(w); step(1'b1, w);
            n_cmp++; if (obs_vec() !== m_exp) begin n_fail++; $display("FAIL loss_cycle: got %h want %h", obs_vec(), m_exp); end
            if (sym_valid && sym_err) errs++;
            if (pl && !locked) begin
                n_cmp++; if ({sym_valid, sym_err} !== 2'b11) begin n_fail++; $display("FAIL loss_edge_err: got %b want 11", {sym_valid, sym_err}); end
            end
        end
        n_cmp++; if (errs !== 4) begin n_fail++; $display("FAIL loss_err_count: got %0d want 4", errs); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_locked: got %b want 0", locked); end
    endtask

    task automatic test_err_recover();
        logic [9:0] w;
        int errs;
        errs = 0;
        push_commas(3);
        for (int i = 0; i < 3; i++) push_sym(BAD);
        for (int i = 0; i < 16; i++) push_sym(D21_5);
        push_sym(BAD); push_sym(D21_5); push_sym(D21_5);
        while (bitq.size() >= 10) begin
            pop_word(w); step(1'b1, w);
            n_cmp++; if (obs_vec() !== m_exp) begin n_fail++; $display("FAIL recover_cycle: got %h want %h", obs_vec(), m_exp); end
            if (sym_valid && sym_err) errs++;
        end
        n_cmp++; if (errs !== 4) begin n_fail++; $display("FAIL recover_err_count: got %0d want 4", errs); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL recover_locked: got %b want 1", locked); end
    endtask

    task automatic test_relatch();
        logic [9:0] w;
        do_reset();
        push_fill(3); push_sym(D21_5);
        push_commas(2);
        for (int phase = 0; phase < 4; phase++) begin
            if (phase == 1) begin push_fill(4); push_commas(1); end
            if (phase >= 2) push_commas(1);
            while (bitq.size() >= 10) begin
                pop_word(w); step(1'b1, w);
                n_cmp++; if (obs_vec() !== m_exp) begin n_fail++; $display("FAIL relatch_cycle: got %h want %h", obs_vec(), m_exp); end
            end
            n_cmp++;
            if (align_offset !== ((phase == 0) ? 4'd3 : 4'd7)) begin
                n_fail++; $display("FAIL relatch_offset: phase %0d got %0d", phase, align_offset);
            end
            n_cmp++;
            if (locked !== (phase == 3)) begin
                n_fail++; $display("FAIL relatch_locked: phase %0d got %b want %b", phase, locked, (phase == 3));
            end
        end
    endtask

    task automatic test_disparity();
        logic [9:0] w;
        bit seen, got_err;
        seen = 1'b0; got_err = 1'b0;
        do_reset();
        push_fill(3); push_sym(D21_5);
        push_commas(3);
        push_sym(D21_5); push_sym(ONES6); push_sym(D21_5); push_sym(D21_5);
        while (bitq.size() >= 10) begin
            pop_word(w); step(1'b1, w);
            n_cmp++; if (obs_vec() !== m_exp) begin n_fail++; $display("FAIL disp_cycle: got %h want %h", obs_vec(), m_exp); end
            if (sym_valid && sym_out == ONES6) begin seen = 1'b1; got_err = sym_err; end
        end
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL disp_symbol_seen: got %b want 1", seen); end
`ifdef RX_DISP_CHECK_EN
        n_cmp++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL disp_err: got %b want 1", got_err); end
`else
        n_cmp++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL disp_err: got %b want 0", got_err); end
`endif
    endtask

    task automatic test_midstream_reset();
        rst = 1'b1; raw_valid = 1'b1; raw_in = D21_5;
        @(posedge clk); #1;
        n_cmp++; if (obs_vec() !== 18'd0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", obs_vec()); end
        n_cmp++; if (sym_out !== 10'd0) begin n_fail++; $display("FAIL midreset_sym_out: got %h want 000", sym_out); end
        rst = 1'b0; raw_valid = 1'b0;
        reset_model();
        bitq.delete();
    endtask

    task automatic test_random();
        logic [9:0] w;
        int r, locks;
        bit pl;
        locks = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            while (bitq.size() < 20) begin
                r = $urandom_range(99);
                if (r < 35) push_sym(($urandom_range(3) == 0) ? K_RDP : K_RDN);
                else if (r < 80) push_sym(D21_5);
                else if (r < 95) push_sym(10'($urandom));
                else push_fill($urandom_range(9, 1));
            end
            pl = locked;
            if ($urandom_range(3) != 0) begin
                pop_word(w); step(1'b1, w);
            end else begin
                step(1'b0, 10'($urandom));
            end
            if (!pl && locked) locks++;
            n_cmp++; if (obs_vec() !== m_exp) begin n_fail++; $display("FAIL random_cycle %0d: got %h want %h", cyc, obs_vec(), m_exp); end
        end
        n_cmp++; if (locks == 0) begin n_fail++; $display("FAIL random_lock_events: got 0 want >0"); end
    endtask

    initial begin
        rst = 1'b1; raw_valid = 1'b0; raw_in = 10'd0;
        reset_model();
        test_reset();
        test_lock_acquire();
        test_err_loss();
        test_err_recover();
        test_relatch();
        test_disparity();
        test_midstream_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
